// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_A,
        ST_GET_B,
        ST_EXEC,
        ST_SEND_HI,
        ST_SEND_LO
    } seq_state_e;

    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b01;
    localparam logic [1:0] SEL_MUL = 2'b10;
    localparam logic [1:0] SEL_MAX = 2'b11;

    localparam logic [7:0] OPC_RSVD_MASK = 8'hFC;

    function automatic logic opcode_legal(input logic [7:0] opc);
        return (opc & OPC_RSVD_MASK) == 8'h00;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational signed ALU: add, sub, mul and max of two N-bit operands, 2N-bit result.
module alu
    import alu_seq_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    input  logic [1:0]     sel_i,
    output logic [2*N-1:0] y_o
);

    logic signed [2*N-1:0] a_ext;
    logic signed [2*N-1:0] b_ext;

    // Widening first keeps every result exact in 2N bits, including the product.
    assign a_ext = (2*N)'(signed'(a_i));
    assign b_ext = (2*N)'(signed'(b_i));

    always_comb begin
        y_o = '0;
        case (sel_i)
            SEL_ADD: y_o = a_ext + b_ext;
            SEL_SUB: y_o = a_ext - b_ext;
            SEL_MUL: y_o = a_ext * b_ext;
            SEL_MAX: y_o = (a_ext > b_ext) ? a_ext : b_ext;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects opcode/A/B frames from the UART RX stream, runs them through the ALU
// and returns the sign-extended 16-bit result as two bytes on a valid/ready TX port.
module alu_uart_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N       = 5,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       err_opcode,
    output logic       err_timeout,
    output logic       err_overrun
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    seq_state_e      state_q;
    logic [1:0]      sel_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [15:0]     res_q;
    logic [CW-1:0]   cnt_q;
    logic            tx_valid_q;
    logic            busy_q;
    logic            err_opcode_q;
    logic            err_timeout_q;
    logic            err_overrun_q;

    logic [2*N-1:0]  alu_y;
    logic [15:0]     res16;

    alu #(.N(N)) u_alu (
        .a_i   (a_q),
        .b_i   (b_q),
        .sel_i (sel_q),
        .y_o   (alu_y)
    );

    assign res16 = 16'(signed'(alu_y));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            res_q         <= '0;
            cnt_q         <= '0;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            err_opcode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            err_opcode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (opcode_legal(rx_data)) begin
                            sel_q   <= rx_data[1:0];
                            cnt_q   <= '0;
                            state_q <= ST_GET_A;
                            busy_q  <= 1'b1;
                        end else begin
                            err_opcode_q <= 1'b1;
                        end
                    end
                end
                ST_GET_A, ST_GET_B: begin
                    // An arriving byte takes priority over an expiring timeout.
                    if (rx_valid) begin
                        cnt_q <= '0;
                        if (state_q == ST_GET_A) begin
                            a_q     <= rx_data[N-1:0];
                            state_q <= ST_GET_B;
                        end else begin
                            b_q     <= rx_data[N-1:0];
                            state_q <= ST_EXEC;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        a_q           <= '0;
                        b_q           <= '0;
                        cnt_q         <= '0;
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        err_timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_EXEC: begin
                    res_q         <= res16;
                    state_q       <= ST_SEND_HI;
                    tx_valid_q    <= 1'b1;
                    err_overrun_q <= rx_valid;
                end
                ST_SEND_HI: begin
                    err_overrun_q <= rx_valid;
                    if (tx_ready) begin
                        state_q <= ST_SEND_LO;
                    end
                end
                ST_SEND_LO: begin
                    err_overrun_q <= rx_valid;
                    if (tx_ready) begin
                        state_q    <= ST_IDLE;
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Byte select is a pure function of registered state, so it cannot move mid-handshake.
    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            ST_SEND_HI: tx_data = res_q[15:8];
            ST_SEND_LO: tx_data = res_q[7:0];
            default:    tx_data = 8'h00;
        endcase
    end

    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign err_opcode  = err_opcode_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with N=5 and a short timeout.
module tb_alu_uart_sequencer;

    localparam int N       = 5;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       busy;
    logic       err_opcode;
    logic       err_timeout;
    logic       err_overrun;

    int checks = 0;
    int errors = 0;

    alu_uart_sequencer #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .busy        (busy),
        .err_opcode  (err_opcode),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-20s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input string tag, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        send_byte(op);
        chk({tag, "_busy_op"}, 16'(busy), 16'd1);
        send_byte(a);
        send_byte(b);
        chk({tag, "_exec_nv"}, 16'(tx_valid), 16'd0);
    endtask

    // Called right after byte B with tx_ready held high.
    task automatic expect_result(input string tag, input logic [7:0] hi, input logic [7:0] lo);
        tick();
        chk({tag, "_hi_valid"}, 16'(tx_valid), 16'd1);
        chk({tag, "_hi_data"}, 16'(tx_data), 16'(hi));
        tick();
        chk({tag, "_lo_valid"}, 16'(tx_valid), 16'd1);
        chk({tag, "_lo_data"}, 16'(tx_data), 16'(lo));
        tick();
        chk({tag, "_done_valid"}, 16'(tx_valid), 16'd0);
        chk({tag, "_done_busy"}, 16'(busy), 16'd0);
    endtask

    initial begin
        int first_to;
        int pulses;

        // Reset state.
        tick();
        tick();
        chk("rst_valid", 16'(tx_valid), 16'd0);
        chk("rst_data", 16'(tx_data), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_errs", 16'({err_opcode, err_timeout, err_overrun}), 16'd0);
        rst_n = 1'b1;
        tick();

        // Add 7+3 = 10; frames back to back exercise the 6-cycle period.
        tx_ready = 1'b1;
        send_frame("add", 8'h00, 8'h07, 8'h03);
        expect_result("add", 8'h00, 8'h0A);
        // Sub 3-7 = -4.
        send_frame("sub", 8'h01, 8'h03, 8'h07);
        expect_result("sub", 8'hFF, 8'hFC);
        // Mul -2*3 = -6; upper operand bits must be ignored (0xFE -> 5'h1E).
        send_frame("mul", 8'h02, 8'hFE, 8'h03);
        expect_result("mul", 8'hFF, 8'hFA);

        // Max with backpressure.
        tx_ready = 1'b0;
        send_frame("max", 8'h03, 8'h07, 8'h03);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("max_bp_valid", 16'(tx_valid), 16'd1);
            chk("max_bp_data", 16'(tx_data), 16'h00);
            tick();
        end
        chk("max_bp_hold", 16'(tx_data), 16'h00);
        tx_ready = 1'b1;
        tick();
        chk("max_lo_data", 16'(tx_data), 16'h07);
        tick();
        chk("max_done_valid", 16'(tx_valid), 16'd0);

        // Illegal opcode.
        send_byte(8'h84);
        chk("badop_pulse", 16'(err_opcode), 16'd1);
        chk("badop_busy", 16'(busy), 16'd0);
        tick();
        chk("badop_pulse_end", 16'(err_opcode), 16'd0);
        chk("badop_no_tx", 16'(tx_valid), 16'd0);
        send_byte(8'h04);
        chk("badop2_pulse", 16'(err_opcode), 16'd1);
        tick();

        // Timeout after A.
        send_byte(8'h00);
        send_byte(8'h01);
        first_to = 0;
        pulses   = 0;
        for (int i = 1; i <= TIMEOUT + 3; i++) begin
            tick();
            if (err_timeout) begin
                pulses++;
                if (first_to == 0) first_to = i;
            end
        end
        chk("to_cycle", 16'(first_to), 16'(TIMEOUT));
        chk("to_pulses", 16'(pulses), 16'd1);
        chk("to_busy", 16'(busy), 16'd0);
        chk("to_no_tx", 16'(tx_valid), 16'd0);

        // Byte arriving on the final timeout cycle wins; discarded A must not leak.
        send_byte(8'h00);
        send_byte(8'h01);
        pulses = 0;
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            if (err_timeout) pulses++;
        end
        send_byte(8'h02);
        if (err_timeout) pulses++;
        chk("bw_no_timeout", 16'(pulses), 16'd0);
        expect_result("bw", 8'h00, 8'h03);

        // Overrun during SEND_HI.
        tx_ready = 1'b0;
        send_frame("ovr", 8'h00, 8'h07, 8'h03);
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        tick();
        rx_valid = 1'b0;
        chk("ovr_pulse", 16'(err_overrun), 16'd1);
        chk("ovr_valid", 16'(tx_valid), 16'd1);
        chk("ovr_hi_data", 16'(tx_data), 16'h00);
        tick();
        chk("ovr_pulse_end", 16'(err_overrun), 16'd0);
        tx_ready = 1'b1;
        tick();
        chk("ovr_lo_data", 16'(tx_data), 16'h0A);
        tick();
        chk("ovr_done", 16'(busy), 16'd0);

        // Reset mid-send.
        tx_ready = 1'b0;
        send_frame("rsn", 8'h01, 8'h03, 8'h07);
        tick();
        chk("rsn_in_send", 16'(tx_valid), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rsn_valid", 16'(tx_valid), 16'd0);
        chk("rsn_busy", 16'(busy), 16'd0);
        tick();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        tick();
        chk("rsn_idle_valid", 16'(tx_valid), 16'd0);
        send_frame("post", 8'h02, 8'h1E, 8'h03);
        expect_result("post", 8'hFF, 8'hFA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
